// File: rtl/vx_dcache_req_arb.sv
// Round-robin arbiter sharing one dcache request port among NUM_REQS clients, with per-requester read credits.
// Define DCACHE_ARB_PERF_EN to add per-requester grant counters and a stall counter.
module vx_dcache_req_arb #(
    parameter int NUM_REQS    = 4,
    parameter int ADDR_WIDTH  = 30,
    parameter int DATA_SIZE   = 4,
    parameter int TAG_WIDTH   = 8,
    parameter int MAX_PENDING = 8,
    localparam int SELW       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS-1:0]               req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0]    req_addr,
    input  logic [NUM_REQS*DATA_SIZE-1:0]     req_byteen,
    input  logic [NUM_REQS*DATA_SIZE*8-1:0]   req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]     req_tag,
    output logic [NUM_REQS-1:0]               req_ready,
    output logic [NUM_REQS-1:0]               rsp_valid,
    output logic [NUM_REQS*DATA_SIZE*8-1:0]   rsp_data,
    output logic [NUM_REQS*TAG_WIDTH-1:0]     rsp_tag,
    input  logic [NUM_REQS-1:0]               rsp_ready,
    output logic                              mem_req_valid,
    output logic                              mem_req_rw,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr,
    output logic [DATA_SIZE-1:0]              mem_req_byteen,
    output logic [DATA_SIZE*8-1:0]            mem_req_data,
    output logic [TAG_WIDTH+SELW-1:0]         mem_req_tag,
    input  logic                              mem_req_ready,
    input  logic                              mem_rsp_valid,
    input  logic [DATA_SIZE*8-1:0]            mem_rsp_data,
    input  logic [TAG_WIDTH+SELW-1:0]         mem_rsp_tag,
    output logic                              mem_rsp_ready,
    output logic                              busy,
    output logic                              tag_err
`ifdef DCACHE_ARB_PERF_EN
    ,
    output logic [NUM_REQS*32-1:0]            perf_grants,
    output logic [31:0]                       perf_stalls
`endif
);

    localparam int PW   = $clog2(MAX_PENDING + 1);
    localparam int NPAD = 1 << SELW;
    localparam int DW   = DATA_SIZE * 8;

    logic                      out_valid;
    logic                      out_rw;
    logic [ADDR_WIDTH-1:0]     out_addr;
    logic [DATA_SIZE-1:0]      out_byteen;
    logic [DW-1:0]             out_data;
    logic [TAG_WIDTH+SELW-1:0] out_tag;
    logic [SELW-1:0]           ptr;
    logic [PW-1:0]             pending [NUM_REQS];

    logic [NUM_REQS-1:0] eligible, pend_nz, inc_vec, dec_vec;
    logic [NPAD-1:0]     elig_pad, rw_pad, rsp_ready_pad;
    logic [SELW:0]       cand;
    logic [SELW-1:0]     grant_idx, rsp_idx;
    logic                grant_any, load, fire, idx_ok, rsp_fire;

    assign elig_pad      = NPAD'(eligible);
    assign rw_pad        = NPAD'(req_rw);
    assign rsp_ready_pad = NPAD'(rsp_ready);

    assign load     = ~out_valid | mem_req_ready;
    assign fire     = load & grant_any;
    assign rsp_idx  = mem_rsp_tag[SELW-1:0];
    assign idx_ok   = ({1'b0, rsp_idx} < (SELW+1)'(NUM_REQS));
    assign rsp_fire = mem_rsp_valid & mem_rsp_ready & idx_ok;

    always_comb begin
        eligible = '0;
        pend_nz  = '0;
        inc_vec  = '0;
        dec_vec  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            eligible[i] = req_valid[i] && (req_rw[i] || (pending[i] < PW'(MAX_PENDING)));
            pend_nz[i]  = (pending[i] != '0);
            inc_vec[i]  = fire && !rw_pad[grant_idx] && (grant_idx == SELW'(i));
            // Responses arriving at a zero count (e.g. issued before a reset) are absorbed silently.
            dec_vec[i]  = rsp_fire && (rsp_idx == SELW'(i)) && pend_nz[i];
        end
    end

    // First eligible requester at or after ptr, wrapping at NUM_REQS (not at 2**SELW).
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = {1'b0, ptr} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(NUM_REQS)) cand = cand - (SELW+1)'(NUM_REQS);
            if (!grant_any && elig_pad[cand[SELW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[SELW-1:0];
            end
        end
    end

    assign req_ready = (reset && fire) ? (NUM_REQS'(1) << grant_idx) : '0;
    assign rsp_valid = (reset && mem_rsp_valid && idx_ok) ? (NUM_REQS'(1) << rsp_idx) : '0;
    assign mem_rsp_ready = idx_ok ? rsp_ready_pad[rsp_idx] : 1'b1;
    assign rsp_data  = {NUM_REQS{mem_rsp_data}};
    assign rsp_tag   = {NUM_REQS{mem_rsp_tag[TAG_WIDTH+SELW-1:SELW]}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_rw     <= 1'b0;
            out_addr   <= '0;
            out_byteen <= '0;
            out_data   <= '0;
            out_tag    <= '0;
            ptr        <= '0;
        end else if (load) begin
            out_valid <= grant_any;
            if (grant_any) begin
                out_rw     <= rw_pad[grant_idx];
                out_addr   <= req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
                out_byteen <= req_byteen[grant_idx*DATA_SIZE +: DATA_SIZE];
                out_data   <= req_data[grant_idx*DW +: DW];
                out_tag    <= {req_tag[grant_idx*TAG_WIDTH +: TAG_WIDTH], grant_idx};
                ptr        <= (grant_idx == SELW'(NUM_REQS-1)) ? '0 : grant_idx + SELW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REQS; i++) pending[i] <= '0;
            tag_err <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (inc_vec[i] && !dec_vec[i])      pending[i] <= pending[i] + PW'(1);
                else if (dec_vec[i] && !inc_vec[i]) pending[i] <= pending[i] - PW'(1);
            end
            if (mem_rsp_valid && !idx_ok) tag_err <= 1'b1;
        end
    end

    assign mem_req_valid  = out_valid;
    assign mem_req_rw     = out_rw;
    assign mem_req_addr   = out_addr;
    assign mem_req_byteen = out_byteen;
    assign mem_req_data   = out_data;
    assign mem_req_tag    = out_tag;
    assign busy           = out_valid | (|pend_nz);

`ifdef DCACHE_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else begin
            if (fire) perf_grants[grant_idx*32 +: 32] <= perf_grants[grant_idx*32 +: 32] + 32'd1;
            if ((|req_valid) && !fire) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vx_dcache_req_arb.sv
// Directed bench for vx_dcache_req_arb: 4-requester instance plus a 3-requester instance for bad-index handling.
module tb_vx_dcache_req_arb;
    localparam int N = 4, AW = 30, DS = 4, TW = 8, MP = 8, DW = 32, MTW = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]      req_valid, req_rw, req_ready, rsp_valid, rsp_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DS-1:0]   req_byteen;
    logic [N*DW-1:0]   req_data, rsp_data;
    logic [N*TW-1:0]   req_tag, rsp_tag;
    logic              mem_req_valid, mem_req_rw, mem_req_ready;
    logic [AW-1:0]     mem_req_addr;
    logic [DS-1:0]     mem_req_byteen;
    logic [DW-1:0]     mem_req_data, mem_rsp_data;
    logic [MTW-1:0]    mem_req_tag, mem_rsp_tag;
    logic              mem_rsp_valid, mem_rsp_ready, busy, tag_err;

    logic [2:0]        req_valid1, req_rw1, req_ready1, rsp_valid1, rsp_ready1;
    logic [3*AW-1:0]   req_addr1;
    logic [3*DS-1:0]   req_byteen1;
    logic [3*DW-1:0]   req_data1, rsp_data1;
    logic [3*TW-1:0]   req_tag1, rsp_tag1;
    logic              mem_req_valid1, mem_req_rw1, mem_req_ready1;
    logic [AW-1:0]     mem_req_addr1;
    logic [DS-1:0]     mem_req_byteen1;
    logic [DW-1:0]     mem_req_data1, mem_rsp_data1;
    logic [MTW-1:0]    mem_req_tag1, mem_rsp_tag1;
    logic              mem_rsp_valid1, mem_rsp_ready1, busy1, tag_err1;

`ifdef DCACHE_ARB_PERF_EN
    logic [N*32-1:0] perf_grants;
    logic [31:0]     perf_stalls;
    logic [3*32-1:0] perf_grants1;
    logic [31:0]     perf_stalls1;
`endif

    vx_dcache_req_arb #(.NUM_REQS(N), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr), .req_byteen(req_byteen),
        .req_data(req_data), .req_tag(req_tag), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ready(rsp_ready),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .mem_rsp_tag(mem_rsp_tag), .mem_rsp_ready(mem_rsp_ready), .busy(busy), .tag_err(tag_err)
`ifdef DCACHE_ARB_PERF_EN
        , .perf_grants(perf_grants), .perf_stalls(perf_stalls)
`endif
    );

    vx_dcache_req_arb #(.NUM_REQS(3), .ADDR_WIDTH(AW), .DATA_SIZE(DS), .TAG_WIDTH(TW), .MAX_PENDING(MP)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_rw(req_rw1), .req_addr(req_addr1), .req_byteen(req_byteen1),
        .req_data(req_data1), .req_tag(req_tag1), .req_ready(req_ready1),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_tag(rsp_tag1), .rsp_ready(rsp_ready1),
        .mem_req_valid(mem_req_valid1), .mem_req_rw(mem_req_rw1), .mem_req_addr(mem_req_addr1),
        .mem_req_byteen(mem_req_byteen1), .mem_req_data(mem_req_data1), .mem_req_tag(mem_req_tag1),
        .mem_req_ready(mem_req_ready1), .mem_rsp_valid(mem_rsp_valid1), .mem_rsp_data(mem_rsp_data1),
        .mem_rsp_tag(mem_rsp_tag1), .mem_rsp_ready(mem_rsp_ready1), .busy(busy1), .tag_err(tag_err1)
`ifdef DCACHE_ARB_PERF_EN
        , .perf_grants(perf_grants1), .perf_stalls(perf_stalls1)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outstanding reads at drain time: r0=3, r1=1, r2=8, r3=3.
    logic [1:0] drain_idx [15] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                   2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int g;
        req_valid = '0; req_rw = '0; rsp_ready = '0; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = '0; mem_rsp_tag = '0;
        req_valid1 = '0; req_rw1 = '0; req_addr1 = '0; req_byteen1 = '0; req_data1 = '0; req_tag1 = '0;
        rsp_ready1 = '0; mem_req_ready1 = 1'b0; mem_rsp_valid1 = 1'b0; mem_rsp_data1 = '0; mem_rsp_tag1 = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]   = 30'h100 + 30'(i);
            req_tag[i*TW +: TW]    = 8'h10 + 8'(i);
            req_data[i*DW +: DW]   = 32'hD000_0000 + 32'(i);
            req_byteen[i*DS +: DS] = 4'hF;
        end

        // reset asserted: combinational outputs forced low even with inputs active
        #1 reset = 1'b0;
        req_valid = 4'hF; mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; rsp_ready = 4'hF;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_mem_req_valid", 64'(mem_req_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_tag_err", 64'(tag_err), 64'h0);
        mem_rsp_valid = 1'b0; rsp_ready = '0; req_valid = '0;
        step();
        reset = 1'b1;

        // fairness: all four read continuously
        req_valid = 4'hF; req_rw = '0; mem_req_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            g = k % 4;
            #1 chk("rr_ready", 64'(req_ready), 64'(1 << g));
            step();
            chk("rr_valid", 64'(mem_req_valid), 64'h1);
            chk("rr_tag", 64'(mem_req_tag), 64'({8'h10 + 8'(g), 2'(g)}));
            chk("rr_addr", 64'(mem_req_addr), 64'(30'h100 + 30'(g)));
            chk("rr_data", 64'(mem_req_data), 64'(32'hD000_0000 + 32'(g)));
        end

        // stall with requester 3 in the stage
        mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("stall_ready", 64'(req_ready), 64'h0);
            step();
            chk("stall_valid", 64'(mem_req_valid), 64'h1);
            chk("stall_tag", 64'(mem_req_tag), 64'({8'h13, 2'd3}));
            chk("stall_addr", 64'(mem_req_addr), 64'h103);
        end
        mem_req_ready = 1'b1;
        #1 chk("stall_next_grant", 64'(req_ready), 64'b0001);
        step();
        chk("stall_next_tag", 64'(mem_req_tag), 64'({8'h10, 2'd0}));
        req_valid = '0;
        step();
        chk("idle_valid", 64'(mem_req_valid), 64'h0);
        chk("idle_busy", 64'(busy), 64'h1);

        // credit limit on requester 2 (already has 2 outstanding)
        req_valid = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            #1 chk("credit_fill", 64'(req_ready), 64'b0100);
            step();
        end
        #1 chk("credit_block", 64'(req_ready), 64'h0);
        req_valid = 4'b1100;
        #1 chk("credit_other", 64'(req_ready), 64'b1000);
        step();
        chk("credit_other_tag", 64'(mem_req_tag), 64'({8'h13, 2'd3}));
        req_valid = 4'b0100; req_rw = 4'b0100;
        #1 chk("credit_write", 64'(req_ready), 64'b0100);
        step();
        chk("credit_write_rw", 64'(mem_req_rw), 64'h1);
        chk("credit_write_tag", 64'(mem_req_tag), 64'({8'h12, 2'd2}));
        req_rw = '0;
        #1 chk("credit_still_block", 64'(req_ready), 64'h0);
        mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h77, 2'd2}; mem_rsp_data = 32'h1234_5678; rsp_ready = 4'b0100;
        #1;
        chk("rsp2_valid", 64'(rsp_valid), 64'b0100);
        chk("rsp2_tag", 64'(rsp_tag), 64'({4{8'h77}}));
        chk("rsp2_same_cycle_block", 64'(req_ready), 64'h0);
        step();
        mem_rsp_valid = 1'b0; rsp_ready = '0;
        #1 chk("credit_regrant", 64'(req_ready), 64'b0100);
        step();
        req_valid = '0;
        step();

        // routing with backpressure from requester 1
        mem_rsp_valid = 1'b1; mem_rsp_tag = {8'hA5, 2'd1}; mem_rsp_data = 32'hCAFE_BABE; rsp_ready = '0;
        #1;
        chk("route_valid", 64'(rsp_valid), 64'b0010);
        chk("route_tag1", 64'(rsp_tag[15:8]), 64'hA5);
        chk("route_data0", 64'(rsp_data[31:0]), 64'hCAFE_BABE);
        chk("route_mem_rdy_lo", 64'(mem_rsp_ready), 64'h0);
        step();
        rsp_ready = 4'b0010;
        #1 chk("route_mem_rdy_hi", 64'(mem_rsp_ready), 64'h1);
        step();
        mem_rsp_valid = 1'b0; rsp_ready = '0;

        // read grant and response for requester 0 in the same cycle
        req_valid = 4'b0001; mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h01, 2'd0}; rsp_ready = 4'hF;
        #1 chk("simul_grant", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0; mem_rsp_valid = 1'b0;
        step();

        // drain: busy must drop exactly on the last expected response
        mem_rsp_valid = 1'b1; rsp_ready = 4'hF;
        for (int k = 0; k < 15; k++) begin
            mem_rsp_tag = {8'h00, drain_idx[k]};
            step();
            chk("drain_busy", 64'(busy), 64'(k < 14));
        end
        mem_rsp_tag = {8'h00, 2'd0};
        step();
        chk("stale_busy", 64'(busy), 64'h0);
        mem_rsp_valid = 1'b0;

        // reset mid-stream
        req_valid = 4'hF;
        step();
        step();
        chk("mid_valid", 64'(mem_req_valid), 64'h1);
        reset = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_tag = {8'h00, 2'd0};
        #1;
        chk("mid_rst_valid", 64'(mem_req_valid), 64'h0);
        chk("mid_rst_ready", 64'(req_ready), 64'h0);
        chk("mid_rst_rsp", 64'(rsp_valid), 64'h0);
        chk("mid_rst_busy", 64'(busy), 64'h0);
        step();
        reset = 1'b1; req_valid = '0;
        step();
        chk("post_rst_stale_busy", 64'(busy), 64'h0);
        mem_rsp_valid = 1'b0; req_valid = 4'hF;
        #1 chk("post_rst_ptr", 64'(req_ready), 64'b0001);
        req_valid = '0;
        step();

        // NUM_REQS=3: index 3 is invalid
        mem_rsp_valid1 = 1'b1; mem_rsp_tag1 = {8'h3C, 2'd2}; rsp_ready1 = '0;
        #1;
        chk("n3_valid_idx_rsp", 64'(rsp_valid1), 64'b100);
        chk("n3_valid_idx_rdy", 64'(mem_rsp_ready1), 64'h0);
        mem_rsp_tag1 = {8'h3C, 2'd3};
        #1;
        chk("bad_idx_rdy", 64'(mem_rsp_ready1), 64'h1);
        chk("bad_idx_rsp", 64'(rsp_valid1), 64'h0);
        chk("bad_idx_err_pre", 64'(tag_err1), 64'h0);
        step();
        chk("bad_idx_err", 64'(tag_err1), 64'h1);
        chk("dut4_no_err", 64'(tag_err), 64'h0);
        mem_rsp_valid1 = 1'b0;
        step();
        chk("bad_idx_sticky", 64'(tag_err1), 64'h1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
